// File: rtl/hamming_pkg.sv
// Shared types and widths for the Hamming(7,4) nibble packer.
package hamming_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SYN_W  = 3;
  localparam int unsigned ERR_W  = 2;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } pack_state_e;

  // One FIFO entry: assembled byte plus per-nibble corrected flags {hi, lo}.
  typedef struct packed {
    logic [BYTE_W-1:0] byte_val;
    logic [ERR_W-1:0]  err;
  } fifo_entry_t;

  // A nibble is flagged if the decoder reported a correction or saw any syndrome.
  function automatic logic nibble_flag(input logic err, input logic [SYN_W-1:0] syn);
    return err || (syn != '0);
  endfunction

endpackage

// File: rtl/hamming_nibble_packer_if.sv
// Handshake and status bundle between the decoder, the packer and the byte consumer.
interface hamming_nibble_packer_if
  import hamming_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic               in_valid;
  logic               in_ready;
  logic [NIB_W-1:0]   in_data;
  logic [SYN_W-1:0]   in_syndrome;
  logic               in_error;
  logic               flush;
  logic               clr_stats;
  logic               out_valid;
  logic               out_ready;
  logic [BYTE_W-1:0]  out_byte;
  logic [ERR_W-1:0]   out_err;
  logic               out_syn_nz;
  logic               half_pending;
  logic [LVL_W-1:0]   fifo_level;
  logic [CNT_W-1:0]   stat_corr;
  logic [CNT_W-1:0]   stat_bytes;

  modport master (
    output in_valid, in_data, in_syndrome, in_error, flush, clr_stats, out_ready,
    input  in_ready, out_valid, out_byte, out_err, out_syn_nz, half_pending,
           fifo_level, stat_corr, stat_bytes
  );

  modport slave (
    input  in_valid, in_data, in_syndrome, in_error, flush, clr_stats, out_ready,
    output in_ready, out_valid, out_byte, out_err, out_syn_nz, half_pending,
           fifo_level, stat_corr, stat_bytes
  );

endinterface

// File: rtl/hamming_sync_fifo.sv
// Single-clock FIFO with occupancy count; storage is reset so the head reads 0 after reset.
module hamming_sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && (level_q != LVL_W'(DEPTH));
  assign pop_ok  = pop_i && (level_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Occupancy: simultaneous push and pop cancel out.
  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok)      level_d = level_q + LVL_W'(1);
    else if (pop_ok && !push_ok) level_d = level_q - LVL_W'(1);
  end

  // Storage, power-of-two pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/hamming_nibble_packer.sv
// Pairs corrected nibbles into bytes (low first), queues them, and keeps saturating stats.
module hamming_nibble_packer
  import hamming_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input logic                    clk,
  input logic                    rst,
  hamming_nibble_packer_if.slave bus
);

  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

  pack_state_e      state_q, state_d;
  logic [NIB_W-1:0] hold_q, hold_d;
  logic             hold_err_q, hold_err_d;
  logic [CNT_W-1:0] corr_q, corr_d, bytes_q, bytes_d;

  logic             in_ready_c, accept_c, flag_c, push_c, pop_c;
  logic [LVL_W-1:0] level_c;
  fifo_entry_t      wr_entry_c, rd_entry_c;
  logic [ENTRY_W-1:0] rd_raw_c;

  assign flag_c     = nibble_flag(bus.in_error, bus.in_syndrome);
  assign in_ready_c = (state_q == ST_LOW) || (level_c < LVL_W'(FIFO_DEPTH));
  assign accept_c   = bus.in_valid && in_ready_c;
  assign pop_c      = (level_c != '0) && bus.out_ready;

  assign wr_entry_c.byte_val = {bus.in_data, hold_q};
  assign wr_entry_c.err      = {flag_c, hold_err_q};
  assign rd_entry_c          = fifo_entry_t'(rd_raw_c);

  // Pack FSM: hold the low nibble, emit a byte on the high nibble; flush drops the held half.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_err_d = hold_err_q;
    push_c     = 1'b0;
    unique case (state_q)
      ST_LOW: begin
        if (accept_c) begin
          hold_d     = bus.in_data;
          hold_err_d = flag_c;
          state_d    = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (accept_c && bus.flush) begin
          hold_d     = bus.in_data;
          hold_err_d = flag_c;
        end else if (accept_c) begin
          push_c  = 1'b1;
          state_d = ST_LOW;
        end else if (bus.flush) begin
          state_d = ST_LOW;
        end
      end
      default: state_d = ST_LOW;
    endcase
  end

  // Saturating statistics; clear takes priority over a same-cycle increment.
  always_comb begin
    corr_d  = corr_q;
    bytes_d = bytes_q;
    if (accept_c && flag_c && (corr_q != '1)) corr_d  = corr_q + CNT_W'(1);
    if (pop_c && (bytes_q != '1))             bytes_d = bytes_q + CNT_W'(1);
    if (bus.clr_stats) begin
      corr_d  = '0;
      bytes_d = '0;
    end
  end

  // State, hold register and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOW;
      hold_q     <= '0;
      hold_err_q <= 1'b0;
      corr_q     <= '0;
      bytes_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_err_q <= hold_err_d;
      corr_q     <= corr_d;
      bytes_q    <= bytes_d;
    end
  end

  hamming_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .wdata_i (wr_entry_c),
    .pop_i   (pop_c),
    .rdata_o (rd_raw_c),
    .level_o (level_c)
  );

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = (level_c != '0);
  assign bus.out_byte     = rd_entry_c.byte_val;
  assign bus.out_err      = rd_entry_c.err;
  assign bus.out_syn_nz   = |rd_entry_c.err;
  assign bus.half_pending = (state_q == ST_HIGH);
  assign bus.fifo_level   = level_c;
  assign bus.stat_corr    = corr_q;
  assign bus.stat_bytes   = bytes_q;

endmodule

// File: tb/tb_hamming_nibble_packer.sv
// Randomised self-checking bench for hamming_nibble_packer against a queue-based model.
module tb_hamming_nibble_packer;
  import hamming_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hamming_nibble_packer_if #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) bus();

  hamming_nibble_packer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: pending low half and a queue of {byte, err{hi,lo}} entries.
  bit          have_low;
  logic [3:0]  low_nib;
  bit          low_flag;
  logic [9:0]  q[$];
  int          m_corr, m_bytes;

  function automatic void reset_model();
    have_low = 0; low_nib = '0; low_flag = 0; q.delete(); m_corr = 0; m_bytes = 0;
  endfunction

  function automatic bit model_ready();
    return !have_low || (q.size() < DEPTH);
  endfunction

  // Drive one cycle starting just after a falling edge; advance the model at the rising edge.
  task automatic drive_cycle(input bit v, input logic [3:0] d, input logic [2:0] syn,
                             input bit e, input bit fl, input bit clr, input bit ordy);
    bit acc, pop, flag;
    bus.in_valid = v; bus.in_data = d; bus.in_syndrome = syn; bus.in_error = e;
    bus.flush = fl; bus.clr_stats = clr; bus.out_ready = ordy;
    acc  = v && model_ready();
    pop  = (q.size() > 0) && ordy;
    flag = e || (syn != 3'd0);
    @(posedge clk);
    if (pop) begin
      void'(q.pop_front());
      if (m_bytes < CMAX) m_bytes++;
    end
    if (acc) begin
      if (flag && m_corr < CMAX) m_corr++;
      if (have_low && !fl) begin
        q.push_back({d, low_nib, flag, low_flag});
        have_low = 0;
      end else begin
        have_low = 1; low_nib = d; low_flag = flag;
      end
    end else if (fl) begin
      have_low = 0;
    end
    if (clr) begin m_corr = 0; m_bytes = 0; end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) drive_cycle(0, 4'h0, 3'd0, 0, 0, 0, ordy);
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_data = 0; bus.in_syndrome = 0; bus.in_error = 0;
    bus.flush = 0; bus.clr_stats = 0; bus.out_ready = 0;
    reset_model();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || bus.fifo_level !== 3'd0 || bus.half_pending !== 1'b0) begin
      failures++; $display("FAIL reset_flags got valid=%b level=%0d half=%b exp 0 0 0", bus.out_valid, bus.fifo_level, bus.half_pending); end
    checks++; if (bus.out_byte !== 8'h00 || bus.out_err !== 2'b00 || bus.out_syn_nz !== 1'b0) begin
      failures++; $display("FAIL reset_data got byte=%h err=%b nz=%b exp 00 00 0", bus.out_byte, bus.out_err, bus.out_syn_nz); end
    checks++; if (bus.stat_corr !== 4'd0 || bus.stat_bytes !== 4'd0) begin
      failures++; $display("FAIL reset_stats got corr=%0d bytes=%0d exp 0 0", bus.stat_corr, bus.stat_bytes); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_basic();
    drive_cycle(1, 4'h3, 3'd0, 0, 0, 0, 0);
    checks++; if (bus.out_valid !== 1'b0 || bus.half_pending !== 1'b1) begin
      failures++; $display("FAIL basic_half got valid=%b half=%b exp 0 1", bus.out_valid, bus.half_pending); end
    drive_cycle(1, 4'hA, 3'd0, 0, 0, 0, 0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'hA3 || bus.out_err !== 2'b00) begin
      failures++; $display("FAIL basic_byte got valid=%b byte=%h err=%b exp 1 a3 00", bus.out_valid, bus.out_byte, bus.out_err); end
    checks++; if (bus.stat_corr !== 4'd0) begin
      failures++; $display("FAIL basic_corr got=%0d exp=0", bus.stat_corr); end
    drive_cycle(0, 4'h0, 3'd0, 0, 0, 0, 1);
    checks++; if (bus.stat_bytes !== 4'd1 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_pop got bytes=%0d valid=%b exp 1 0", bus.stat_bytes, bus.out_valid); end
  endtask

  task automatic test_flags();
    drive_cycle(1, 4'h5, 3'b101, 1, 0, 0, 0);
    drive_cycle(1, 4'hC, 3'd0, 0, 0, 0, 0);
    checks++; if (bus.out_byte !== 8'hC5 || bus.out_err !== 2'b01 || bus.out_syn_nz !== 1'b1) begin
      failures++; $display("FAIL flags_byte got byte=%h err=%b nz=%b exp c5 01 1", bus.out_byte, bus.out_err, bus.out_syn_nz); end
    checks++; if (bus.stat_corr !== 4'd1) begin
      failures++; $display("FAIL flags_corr got=%0d exp=1", bus.stat_corr); end
    idle(2, 1);
  endtask

  task automatic test_backpressure();
    logic [3:0] nib [9];
    logic [7:0] exp_b;
    for (int i = 0; i < 9; i++) begin
      nib[i] = 4'($urandom);
      drive_cycle(1, nib[i], 3'd0, 0, 0, 0, 0);
    end
    checks++; if (bus.fifo_level !== 3'd4 || bus.half_pending !== 1'b1 || bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_full got level=%0d half=%b rdy=%b exp 4 1 0", bus.fifo_level, bus.half_pending, bus.in_ready); end
    for (int b = 0; b < 4; b++) begin
      exp_b = {nib[2*b+1], nib[2*b]};
      checks++; if (bus.out_valid !== 1'b1 || bus.out_byte !== exp_b) begin
        failures++; $display("FAIL bp_order%0d got valid=%b byte=%h exp 1 %h", b, bus.out_valid, bus.out_byte, exp_b); end
      if (b == 0) begin
        drive_cycle(1, 4'hF, 3'd0, 0, 0, 0, 1);
        checks++; if (bus.in_ready !== 1'b1 || bus.fifo_level !== 3'd3) begin
          failures++; $display("FAIL bp_release got rdy=%b level=%0d exp 1 3", bus.in_ready, bus.fifo_level); end
      end else begin
        drive_cycle(0, 4'h0, 3'd0, 0, 0, 0, 1);
      end
    end
    drive_cycle(0, 4'h0, 3'd0, 0, 1, 0, 1);
    checks++; if (bus.out_valid !== 1'b0 || bus.half_pending !== 1'b0) begin
      failures++; $display("FAIL bp_drain got valid=%b half=%b exp 0 0", bus.out_valid, bus.half_pending); end
  endtask

  task automatic test_flush();
    drive_cycle(1, 4'h7, 3'd0, 0, 0, 0, 0);
    drive_cycle(0, 4'h0, 3'd0, 0, 1, 0, 0);
    checks++; if (bus.half_pending !== 1'b0) begin
      failures++; $display("FAIL flush_half got=%b exp=0", bus.half_pending); end
    drive_cycle(1, 4'h1, 3'd0, 0, 0, 0, 0);
    drive_cycle(1, 4'h2, 3'd0, 0, 0, 0, 0);
    checks++; if (bus.fifo_level !== 3'd1 || bus.out_byte !== 8'h21) begin
      failures++; $display("FAIL flush_byte got level=%0d byte=%h exp 1 21", bus.fifo_level, bus.out_byte); end
    // Flush coinciding with a new nibble: held 0x9 is replaced by 0x4.
    drive_cycle(1, 4'h9, 3'd0, 0, 0, 0, 1);
    drive_cycle(1, 4'h4, 3'd0, 0, 1, 0, 0);
    drive_cycle(1, 4'h6, 3'd0, 0, 0, 0, 0);
    checks++; if (bus.fifo_level !== 3'd1 || bus.out_byte !== 8'h64) begin
      failures++; $display("FAIL flush_accept got level=%0d byte=%h exp 1 64", bus.fifo_level, bus.out_byte); end
    idle(2, 1);
  endtask

  task automatic test_saturation();
    drive_cycle(0, 4'h0, 3'd0, 0, 0, 1, 1);
    for (int i = 0; i < 17; i++)
      drive_cycle(1, 4'($urandom), 3'($urandom_range(1, 7)), 1'($urandom), 0, 0, 1);
    checks++; if (bus.stat_corr !== 4'hF) begin
      failures++; $display("FAIL sat_corr got=%h exp=f", bus.stat_corr); end
    drive_cycle(1, 4'h1, 3'd0, 1, 0, 1, 1);
    checks++; if (bus.stat_corr !== 4'd0 || bus.stat_bytes !== 4'd0) begin
      failures++; $display("FAIL clr_stats got corr=%0d bytes=%0d exp 0 0", bus.stat_corr, bus.stat_bytes); end
    drive_cycle(0, 4'h0, 3'd0, 0, 1, 0, 1);
    idle(3, 1);
  endtask

  task automatic test_random();
    logic [9:0] h;
    for (int n = 0; n < 400; n++) begin
      drive_cycle(1'($urandom_range(0, 3) != 0), 4'($urandom),
                  ($urandom_range(0, 1) == 1) ? 3'($urandom) : 3'd0, 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0),
                  1'($urandom_range(0, 2) == 0));
      checks++; if (bus.out_valid !== (q.size() > 0) || bus.fifo_level !== 3'(q.size())
                    || bus.half_pending !== have_low || bus.in_ready !== model_ready()) begin
        failures++; $display("FAIL rand_ctrl@%0d got v=%b lvl=%0d half=%b rdy=%b exp v=%b lvl=%0d half=%b rdy=%b",
          n, bus.out_valid, bus.fifo_level, bus.half_pending, bus.in_ready,
          q.size() > 0, q.size(), have_low, model_ready()); end
      checks++; if (bus.stat_corr !== 4'(m_corr) || bus.stat_bytes !== 4'(m_bytes)) begin
        failures++; $display("FAIL rand_stats@%0d got corr=%0d bytes=%0d exp %0d %0d",
          n, bus.stat_corr, bus.stat_bytes, m_corr, m_bytes); end
      if (q.size() > 0) begin
        h = q[0];
        checks++; if (bus.out_byte !== h[9:2] || bus.out_err !== h[1:0] || bus.out_syn_nz !== (|h[1:0])) begin
          failures++; $display("FAIL rand_head@%0d got byte=%h err=%b nz=%b exp %h %b %b",
            n, bus.out_byte, bus.out_err, bus.out_syn_nz, h[9:2], h[1:0], |h[1:0]); end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) drive_cycle(1, 4'($urandom), 3'd1, 0, 0, 0, 0);
    checks++; if (bus.fifo_level < 3'd2) begin
      failures++; $display("FAIL areset_setup got level=%0d exp>=2", bus.fifo_level); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.fifo_level !== 3'd0 || bus.half_pending !== 1'b0
                  || bus.out_byte !== 8'h00 || bus.out_err !== 2'b00 || bus.stat_corr !== 4'd0) begin
      failures++; $display("FAIL areset_async got v=%b lvl=%0d half=%b byte=%h err=%b corr=%0d exp all 0",
        bus.out_valid, bus.fifo_level, bus.half_pending, bus.out_byte, bus.out_err, bus.stat_corr); end
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    drive_cycle(1, 4'hE, 3'd0, 0, 0, 0, 0);
    drive_cycle(1, 4'hB, 3'd0, 0, 0, 0, 0);
    checks++; if (bus.fifo_level !== 3'd1 || bus.out_byte !== 8'hBE || bus.out_err !== 2'b00) begin
      failures++; $display("FAIL areset_post got level=%0d byte=%h err=%b exp 1 be 00", bus.fifo_level, bus.out_byte, bus.out_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
